// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and the wrap-around BCD step used by the alarm
// time setter.
package alarm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_HOUR,
    T_MIN,
    A_HOUR,
    A_MIN
  } setter_state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;

  // One increment or decrement of a two-digit BCD field that wraps between
  // 00 and limit; the ones digit carries into / borrows from the tens digit.
  function automatic bcd_pair_t bcd_step(input bcd_pair_t cur, input logic up,
                                         input int unsigned limit);
    bcd_pair_t lim;
    bcd_pair_t res;
    lim.tens = 4'(limit / 10);
    lim.ones = 4'(limit % 10);
    res      = cur;
    if (up) begin
      if (cur == lim) begin
        res = '0;
      end else if (cur.ones == 4'd9) begin
        res.tens = cur.tens + 4'd1;
        res.ones = 4'd0;
      end else begin
        res.ones = cur.ones + 4'd1;
      end
    end else begin
      if (cur == '0) begin
        res = lim;
      end else if (cur.ones == 4'd0) begin
        res.tens = cur.tens - 4'd1;
        res.ones = 4'd9;
      end else begin
        res.ones = cur.ones - 4'd1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alarm_time_setter_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level counter and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES + 3 > 2) ? $clog2(DEBOUNCE_CYCLES + 3) : 1;
  localparam logic [CW-1:0] ACC_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_armed;

  // After reset the path stays disarmed until the synchronized input has
  // been low for DEBOUNCE_CYCLES+2 cycles (the two stale synchronizer zeros
  // plus a full debounce window), so a button held through reset is ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (!r_armed) begin
        if (r_sync2) begin
          r_cnt <= '0;
        end else if (r_cnt == ARM_LAST) begin
          r_armed <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == ACC_LAST) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/alarm_time_setter.sv
// Button-driven editor for the wall-clock preset and the alarm time, with
// load strobe for the watch and alarm enable toggle.
module alarm_time_setter
  import alarm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] hourdec_init,
  output logic [3:0] hourone_init,
  output logic [3:0] mindec_init,
  output logic [3:0] minone_init,
  output logic       time_load,
  output logic [3:0] hourdec_bud,
  output logic [3:0] hourone_bud,
  output logic [3:0] mindec_bud,
  output logic [3:0] minone_bud,
  output logic       bud_en,
  output logic [2:0] edit_field
);

  logic [2:0]    w_level;
  logic [2:0]    w_press;
  logic          w_ev_mode;
  logic          w_ev_up;
  logic          w_ev_dn;

  setter_state_t r_state;
  setter_state_t w_next;
  logic [2:0]    w_edit;

  bcd_pair_t     r_t_hour;
  bcd_pair_t     r_t_min;
  bcd_pair_t     r_a_hour;
  bcd_pair_t     r_a_min;
  logic          r_bud_en;
  logic          r_time_load;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rstn(rstn), .btn_raw(btn_mode), .level(w_level[0]), .press(w_press[0])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rstn(rstn), .btn_raw(btn_up), .level(w_level[1]), .press(w_press[1])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rstn(rstn), .btn_raw(btn_down), .level(w_level[2]), .press(w_press[2])
  );

  // Mode beats everything; up and down arriving together cancel each other.
  assign w_ev_mode = w_press[0] & w_level[0];
  assign w_ev_up   = w_press[1] & w_level[1] & ~w_press[2] & ~w_press[0];
  assign w_ev_dn   = w_press[2] & w_level[2] & ~w_press[1] & ~w_press[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_edit = '0;
    case (r_state)
      IDLE: begin
        if (w_ev_mode) w_next = T_HOUR;
      end
      T_HOUR: begin
        w_edit = 3'b001;
        if (w_ev_mode) w_next = T_MIN;
      end
      T_MIN: begin
        w_edit = 3'b010;
        if (w_ev_mode) w_next = A_HOUR;
      end
      A_HOUR: begin
        w_edit = 3'b101;
        if (w_ev_mode) w_next = A_MIN;
      end
      A_MIN: begin
        w_edit = 3'b110;
        if (w_ev_mode) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_t_hour    <= '0;
      r_t_min     <= '0;
      r_a_hour    <= '0;
      r_a_min     <= '0;
      r_bud_en    <= 1'b0;
      r_time_load <= 1'b0;
    end else begin
      r_time_load <= (r_state == T_MIN) && w_ev_mode;
      if (w_ev_up || w_ev_dn) begin
        case (r_state)
          IDLE:    if (w_ev_up) r_bud_en <= ~r_bud_en;
          T_HOUR:  r_t_hour <= bcd_step(r_t_hour, w_ev_up, HOUR_MAX);
          T_MIN:   r_t_min  <= bcd_step(r_t_min,  w_ev_up, MIN_MAX);
          A_HOUR:  r_a_hour <= bcd_step(r_a_hour, w_ev_up, HOUR_MAX);
          A_MIN:   r_a_min  <= bcd_step(r_a_min,  w_ev_up, MIN_MAX);
          default: ;
        endcase
      end
    end
  end

  assign hourdec_init = r_t_hour.tens;
  assign hourone_init = r_t_hour.ones;
  assign mindec_init  = r_t_min.tens;
  assign minone_init  = r_t_min.ones;
  assign time_load    = r_time_load;
  assign hourdec_bud  = r_a_hour.tens;
  assign hourone_bud  = r_a_hour.ones;
  assign mindec_bud   = r_a_min.tens;
  assign minone_bud   = r_a_min.ones;
  assign bud_en       = r_bud_en;
  assign edit_field   = w_edit;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed bench for alarm_time_setter with a short debounce window.
module tb_alarm_time_setter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [3:0] hourdec_init, hourone_init, mindec_init, minone_init;
  logic [3:0] hourdec_bud, hourone_bud, mindec_bud, minone_bud;
  logic       time_load;
  logic       bud_en;
  logic [2:0] edit_field;

  int n_checks = 0;
  int n_errors = 0;
  int tl_cnt   = 0;
  logic [15:0] tl_val = '0;

  alarm_time_setter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .hourdec_init(hourdec_init), .hourone_init(hourone_init),
    .mindec_init(mindec_init), .minone_init(minone_init),
    .time_load(time_load),
    .hourdec_bud(hourdec_bud), .hourone_bud(hourone_bud),
    .mindec_bud(mindec_bud), .minone_bud(minone_bud),
    .bud_en(bud_en), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  wire [15:0] w_init = {hourdec_init, hourone_init, mindec_init, minone_init};
  wire [15:0] w_bud  = {hourdec_bud, hourone_bud, mindec_bud, minone_bud};

  always @(negedge clk) begin
    if (time_load === 1'b1) begin
      tl_cnt = tl_cnt + 1;
      tl_val = w_init;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    @(negedge clk);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int adv;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);

    chk("rst_edit", edit_field, 3'b000);
    chk("rst_bud_en", bud_en, 1'b0);
    chk("rst_time_load", time_load, 1'b0);
    chk("rst_init", w_init, 16'h0000);
    chk("rst_bud", w_bud, 16'h0000);

    press(1'b0, 1'b1, 1'b0);
    chk("idle_up_on", bud_en, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    chk("idle_up_off", bud_en, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    chk("idle_down_ignored", bud_en, 1'b0);
    chk("idle_init", w_init, 16'h0000);
    chk("idle_bud", w_bud, 16'h0000);

    press(1'b1, 1'b0, 1'b0);
    chk("t_hour_edit", edit_field, 3'b001);
    for (int i = 1; i <= 25; i++) begin
      press(1'b0, 1'b1, 1'b0);
      if (i == 23) chk("hour_23", {hourdec_init, hourone_init}, 8'h23);
      if (i == 24) chk("hour_wrap_00", {hourdec_init, hourone_init}, 8'h00);
    end
    chk("hour_01", {hourdec_init, hourone_init}, 8'h01);
    chk("hour_min_untouched", {mindec_init, minone_init}, 8'h00);

    press(1'b1, 1'b0, 1'b0);
    chk("t_min_edit", edit_field, 3'b010);
    press(1'b0, 1'b0, 1'b1);
    chk("min_wrap_59", {mindec_init, minone_init}, 8'h59);
    chk("min_hour_untouched", {hourdec_init, hourone_init}, 8'h01);
    chk("no_load_yet", tl_cnt, 0);

    press(1'b1, 1'b0, 1'b0);
    chk("a_hour_edit", edit_field, 3'b101);
    chk("load_once", tl_cnt, 1);
    chk("load_value", tl_val, 16'h0159);
    chk("init_after_load", w_init, 16'h0159);

    press(1'b0, 1'b0, 1'b1);
    chk("a_hour_wrap_23", {hourdec_bud, hourone_bud}, 8'h23);
    press(1'b1, 1'b0, 1'b0);
    chk("a_min_edit", edit_field, 3'b110);
    for (int i = 1; i <= 61; i++) begin
      press(1'b0, 1'b1, 1'b0);
      if (i == 59) chk("a_min_59", {mindec_bud, minone_bud}, 8'h59);
      if (i == 60) chk("a_min_wrap_00", {mindec_bud, minone_bud}, 8'h00);
    end
    chk("a_min_01", {mindec_bud, minone_bud}, 8'h01);
    press(1'b1, 1'b0, 1'b0);
    chk("back_idle", edit_field, 3'b000);
    chk("bud_2301", w_bud, 16'h2301);
    chk("no_second_load", tl_cnt, 1);
    chk("init_held", w_init, 16'h0159);

    press(1'b0, 1'b1, 1'b0);
    chk("bud_en_set", bud_en, 1'b1);

    // Bounce on mode, then steady high: one advance, 6 edges after sampling.
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      btn_mode = 1'b1;
      repeat (3) @(negedge clk);
      btn_mode = 1'b0;
      repeat (2) @(negedge clk);
    end
    btn_mode = 1'b1;
    adv = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (adv < 0 && edit_field !== 3'b000) adv = i;
    end
    chk("bounce_latency", adv, 6);
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_one_step", edit_field, 3'b001);

    press(1'b1, 1'b1, 1'b0);
    chk("mode_up_advance", edit_field, 3'b010);
    chk("mode_up_hour_kept", {hourdec_init, hourone_init}, 8'h01);
    press(1'b0, 1'b1, 1'b1);
    chk("up_down_dropped", {mindec_init, minone_init}, 8'h59);
    chk("up_down_state", edit_field, 3'b010);
    press(1'b1, 1'b0, 1'b0);
    chk("second_load", tl_cnt, 2);
    press(1'b1, 1'b0, 1'b0);
    chk("pre_reset_edit", edit_field, 3'b110);
    chk("pre_reset_bud_en", bud_en, 1'b1);

    @(negedge clk);
    btn_up = 1'b1;
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("areset_edit", edit_field, 3'b000);
    chk("areset_bud_en", bud_en, 1'b0);
    chk("areset_bud", w_bud, 16'h0000);
    chk("areset_init", w_init, 16'h0000);
    chk("areset_time_load", time_load, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("held_no_event", bud_en, 1'b0);
    chk("held_idle", edit_field, 3'b000);
    btn_up = 1'b0;
    repeat (15) @(negedge clk);
    press(1'b0, 1'b1, 1'b0);
    chk("post_reset_press", bud_en, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_time_setter.md
# alarm_time_setter

Button-driven front end for the alarm clock: debounces three push buttons and runs an edit state machine. It produces the BCD wall-clock preset (`*_init`) with a one-cycle load strobe, the BCD alarm time (`*_bud`), and the alarm enable. It sits between the board buttons and the watch/sound_control inputs of the alarm top, on the 100 MHz system clock.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive stable cycles before a button level is accepted (20 ms at 100 MHz); minimum 1.
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `btn_mode`  in  1  raw, asynchronous button; advances the edit field.
- `btn_up`  in  1  raw button; increments the selected field, or toggles the alarm enable in IDLE.
- `btn_down`  in  1  raw button; decrements the selected field.
- `hourdec_init`, `hourone_init`, `mindec_init`, `minone_init`  out  4 each  BCD preset for the watch.
- `time_load`  out  1  one-cycle strobe: `*_init` is to be loaded.
- `hourdec_bud`, `hourone_bud`, `mindec_bud`, `minone_bud`  out  4 each  BCD alarm time.
- `bud_en`  out  1  alarm enable.
- `edit_field`  out  3  one-hot field being edited for display blink:
  - bit0 = hours
  - bit1 = minutes
  - bit2 = alarm (set together with bit0 or bit1)
  - 0 in IDLE

## Operation
- Each button path: 2-flop synchronizer, then stable counter. The accepted level changes after `DEBOUNCE_CYCLES` consecutive cycles of the new synchronized value; the counter clears on any mismatch. The rising edge of the accepted level gives a one-cycle press event. Releases produce no event. There is no auto-repeat.
- FSM states: IDLE → T_HOUR → T_MIN → A_HOUR → A_MIN → IDLE. Each step is taken on a `mode` event.
- Leaving T_MIN asserts `time_load`.
- IDLE:
  - `up` event toggles `bud_en`.
  - `down` event is ignored.
- Edit states:
  - `up` event increments the selected field; `down` event decrements it.
  - Hours wrap 23→00 and 00→23.
  - Minutes wrap 59→00 and 00→59.
  - Arithmetic is done on the two BCD digits directly: the ones digit wraps 9→0 with carry into the tens digit, or 0→9 with borrow from it. The other field is untouched.
- Simultaneous events in the same cycle:
  - `mode` wins and `up`/`down` are dropped.
  - `up` and `down` together (without `mode`) are both dropped.
- Outputs never hold an illegal BCD value (hours ≤ 23, minutes ≤ 59).

## Timing
- Reset (asynchronous, any state, mid-edit included):
  - FSM goes to IDLE.
  - All `*_init` and `*_bud` digits = 0.
  - `bud_en` = 0, `time_load` = 0, `edit_field` = 0.
  - Synchronizers, counters and accepted levels = 0.
- Press latency: a raw rise sampled at edge k gives a press event high during cycle k+2+`DEBOUNCE_CYCLES`. The resulting state or digit register changes at the following edge.
- `time_load` is registered. It is high for exactly the first cycle in A_HOUR. `*_init` holds its final value in that cycle and stays stable until the next edit of the time fields.
- `*_bud` and `bud_en` change only at clock edges following events. They are glitch-free register outputs.
- A button held continuously produces exactly one event. A bounce shorter than `DEBOUNCE_CYCLES` produces none.

## Structure
- Package `alarm_pkg` holds:
  - `setter_state_t` enum {IDLE, T_HOUR, T_MIN, A_HOUR, A_MIN}.
  - BCD limit constants: HOUR_MAX = 23, MIN_MAX = 59, bcd digit type `logic [3:0]`.
- Sub-module `btn_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `rstn`, `btn_raw`, `level`, `press`) is instantiated three times.
- The BCD inc/dec function with a wrap limit lives in `alarm_pkg` and is shared by the hour and minute fields.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset, then pulse `btn_up` in IDLE for 10 cycles → `bud_en` goes 0→1, one event. A second press → back to 0. All digits read 00:00.
- Mode to T_HOUR, `up` ×25 → `hour*_init` = 0,1 (01) after 25 presses, passing 23→00. Mode to T_MIN, `down` ×1 → 59. Mode → `time_load` high exactly 1 cycle, `*_init` = 01:59.
- A_HOUR `down` from 00 → 23. A_MIN `up` ×61 from 00 → 01. Mode → IDLE, `*_bud` = 23:01, `time_load` stays 0.
- `btn_mode` bounce of 3 cycles high / 2 low repeated for 40 cycles, then steady → exactly one state advance. Event timing = rise edge + 6 cycles.
- `up` and `down` events in the same cycle in T_MIN → field unchanged. `mode` + `up` together in T_HOUR → advances to T_MIN, hours unchanged.
- Assert `rstn` low asynchronously mid-cycle while in A_MIN with `bud_en`=1 → all outputs 0 immediately, FSM in IDLE, and no press event after `rstn` deasserts while a button is held.
